// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states
// and helpers that map an access width to its size and byte mask.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RWAIT = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  // Access size in bytes; codes 3/6/7 are rejected elsewhere, so 4 is harmless for them.
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3)
      3'd0, 3'd4: return 3'd1;
      3'd1, 3'd5: return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] byte_mask(input logic [2:0] funct3);
    case (size_of(funct3))
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of the raw memory word according to the load funct3.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_B:    o_data = {{24{i_rdata[7]}}, i_rdata[7:0]};
      F3_H:    o_data = {{16{i_rdata[15]}}, i_rdata[15:0]};
      F3_W:    o_data = i_rdata;
      F3_BU:   o_data = {24'd0, i_rdata[7:0]};
      F3_HU:   o_data = {16'd0, i_rdata[15:0]};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: accepts one request at a time, drives the 4-bank byte memory
// and returns exactly one (possibly erroneous) response per request.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int READ_LAT = 1,
  parameter int MEM_AW   = 16
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wr,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(READ_LAT - 1);

  lsu_state_e    r_state;
  logic          r_ready;
  logic [2:0]    r_funct3;
  logic [CW-1:0] r_cnt;
  logic          r_resp_valid;
  logic [31:0]   r_resp_rdata;
  logic          r_resp_err;
  logic [31:0]   r_raddr;
  logic [31:0]   r_waddr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wr;

  logic          w_accept;
  logic [2:0]    w_size;
  logic          w_bad_f3;
  logic          w_oor;
  logic          w_err;
  logic [31:0]   w_ext;

  assign w_accept = req_valid & r_ready;
  assign w_size   = size_of(req_funct3);
  assign w_bad_f3 = req_we ? (req_funct3 > F3_W)
                           : (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
  // Last byte must stay inside the window: addr + size may reach 2^MEM_AW but not exceed it.
  assign w_oor    = (|req_addr[31:MEM_AW]) ||
                    (({1'b0, req_addr[MEM_AW-1:0]} + {{(MEM_AW-2){1'b0}}, w_size})
                      > {1'b1, {MEM_AW{1'b0}}});
  assign w_err    = w_bad_f3 | w_oor;

  lsu_load_ext u_load_ext (
    .i_funct3 (r_funct3),
    .i_rdata  (mem_rdata),
    .o_data   (w_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ready      <= 1'b1;
      r_funct3     <= '0;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_raddr      <= '0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_wr         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ready  <= 1'b0;
            r_funct3 <= req_funct3;
            if (w_err) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= '0;
              r_resp_err   <= 1'b1;
            end else if (req_we) begin
              r_state <= WRITE;
              r_waddr <= req_addr;
              r_wdata <= req_wdata;
              r_wr    <= byte_mask(req_funct3);
            end else begin
              r_state <= RWAIT;
              r_raddr <= req_addr;
              r_cnt   <= '0;
            end
          end
        end
        WRITE: begin
          r_wr         <= '0;
          r_state      <= RESP;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b0;
        end
        RWAIT: begin
          if (r_cnt == LAST_CNT) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_ext;
            r_resp_err   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state      <= IDLE;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_raddr  = r_raddr;
  assign mem_waddr  = r_waddr;
  assign mem_wdata  = r_wdata;
  assign mem_wr     = r_wr;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed scenarios followed by random requests,
// checked against a byte-array reference model of memory and the extension rules.
module tb_lsu_mem_ctrl;

  localparam int READ_LAT = 1;
  localparam int MEM_AW   = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_raddr;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wr;
  logic [31:0] mem_rdata;

  int compareCnt = 0;
  int failCnt    = 0;

  logic [7:0] envMem [0:65535];
  logic [7:0] refMem [0:65535];
  bit         memCleared = 1'b0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(
    .READ_LAT (READ_LAT),
    .MEM_AW   (MEM_AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_raddr  (mem_raddr),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wr     (mem_wr),
    .mem_rdata  (mem_rdata)
  );

  // Bank k of the memory serves byte address base+k, so byte k of a word lands at base+k.
  always @(posedge clk) begin
    if (!memCleared) begin
      for (int i = 0; i < 65536; i++) envMem[i] <= 8'h00;
      memCleared <= 1'b1;
    end else begin
      for (int k = 0; k < 4; k++)
        if (mem_wr[k]) envMem[16'(mem_waddr + 32'(k))] <= mem_wdata[8*k +: 8];
    end
  end

  always_comb begin
    mem_rdata = '0;
    for (int k = 0; k < 4; k++)
      mem_rdata[8*k +: 8] = envMem[16'(mem_raddr + 32'(k))];
  end

  function automatic int refSize(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit refIsErr(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    bit     badF3;
    longint lastByte;
    badF3    = we ? (f3 > 3'd2) : (f3 inside {3'd3, 3'd6, 3'd7});
    lastByte = longint'(addr) + longint'(refSize(f3)) - 1;
    return badF3 || (lastByte >= (longint'(1) << MEM_AW));
  endfunction

  function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] addr);
    int     n;
    longint val;
    n   = refSize(f3);
    val = 0;
    for (int i = 0; i < n; i++)
      val += longint'(refMem[int'(addr) + i]) << (8 * i);
    if (f3 < 3'd4 && val >= (longint'(1) << (8 * n - 1)))
      val -= (longint'(1) << (8 * n));
    return val[31:0];
  endfunction

  task automatic refStore(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    for (int i = 0; i < refSize(f3); i++)
      refMem[int'(addr) + i] = wdata[8*i +: 8];
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input int holdCycles);
    bit          expErr;
    logic [31:0] expData;
    int          expLat;
    int          cyc;
    int          writeCycles;
    logic [3:0]  seenWr;
    logic [31:0] seenWaddr;
    logic [31:0] seenWdata;
    bit          raddrOk;
    bit          gotResp;
    expErr  = refIsErr(we, f3, addr);
    expData = (expErr || we) ? 32'd0 : refLoad(f3, addr);
    expLat  = expErr ? 1 : (we ? 2 : READ_LAT + 1);
    seenWr = '0; seenWaddr = '0; seenWdata = '0;

    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;

    cyc = 1; writeCycles = 0; raddrOk = 1'b1; gotResp = 1'b0;
    while (cyc <= 10) begin
      if (mem_wr !== 4'd0) begin
        writeCycles++;
        seenWr = mem_wr; seenWaddr = mem_waddr; seenWdata = mem_wdata;
      end
      if (!we && !expErr && cyc <= READ_LAT && mem_raddr !== addr) raddrOk = 1'b0;
      if (resp_valid === 1'b1) begin
        gotResp = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end

    checkOutput("resp_latency", gotResp ? 32'(cyc) : 32'd0, 32'(expLat));
    checkOutput("write_cycles", 32'(writeCycles), (we && !expErr) ? 32'd1 : 32'd0);
    if (we && !expErr) begin
      checkOutput("mem_wr_mask", 32'(seenWr), 32'((1 << refSize(f3)) - 1));
      checkOutput("mem_waddr", seenWaddr, addr);
      checkOutput("mem_wdata", seenWdata, wdata);
      refStore(f3, addr, wdata);
    end
    if (!we && !expErr) checkOutput("mem_raddr_held", 32'(raddrOk), 32'd1);

    // A competing request during the hold must not be taken while the response waits.
    for (int h = 0; h <= holdCycles; h++) begin
      if (h > 0) begin
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'($urandom_range(0, 63));
        req_wdata  = $urandom;
        @(posedge clk); #1;
      end
      checkOutput("resp_valid_hold", 32'(resp_valid), 32'd1);
      checkOutput("resp_err", 32'(resp_err), 32'(expErr));
      checkOutput("resp_rdata", resp_rdata, expData);
      checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
      checkOutput("mem_wr_quiet", 32'(mem_wr), 32'd0);
    end

    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checkOutput("resp_valid_drop", 32'(resp_valid), 32'd0);
    checkOutput("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared=%0d", compareCnt);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          sel;
    logic [31:0] addr;
    logic [31:0] wd;

    for (int i = 0; i < 65536; i++) refMem[i] = 8'h00;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
    checkOutput("rst_mem_raddr", mem_raddr, 32'd0);
    checkOutput("rst_mem_waddr", mem_waddr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_mem_wr", 32'(mem_wr), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed: byte store");
    applyStimulus(1'b1, 3'd0, 32'h0000_0010, 32'hAABB_CCDD, 0);

    $display("[TB] directed: signed/unsigned byte load");
    applyStimulus(1'b1, 3'd0, 32'h0000_0020, 32'h0000_0080, 0);
    applyStimulus(1'b0, 3'd0, 32'h0000_0020, 32'h0, 0);
    applyStimulus(1'b0, 3'd4, 32'h0000_0020, 32'h0, 0);

    $display("[TB] directed: misaligned word");
    applyStimulus(1'b1, 3'd2, 32'h0000_0003, 32'h1234_5678, 0);
    applyStimulus(1'b0, 3'd2, 32'h0000_0003, 32'h0, 0);
    applyStimulus(1'b0, 3'd1, 32'h0000_0003, 32'h0, 0);

    $display("[TB] directed: error cases");
    applyStimulus(1'b0, 3'd2, 32'h0000_FFFE, 32'h0, 0);
    applyStimulus(1'b0, 3'd2, 32'h0001_0000, 32'h0, 0);
    applyStimulus(1'b0, 3'd3, 32'h0000_0000, 32'h0, 0);
    applyStimulus(1'b1, 3'd2, 32'h0000_FFFC, 32'hCAFE_F00D, 0);
    applyStimulus(1'b0, 3'd5, 32'h0000_FFFE, 32'h0, 0);

    $display("[TB] directed: response backpressure");
    applyStimulus(1'b0, 3'd2, 32'h0000_0010, 32'h0, 5);

    $display("[TB] directed: reset during write");
    wd = $urandom;
    checkOutput("mid_req_ready", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h0000_4000;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("mid_mem_wr_before", 32'(mem_wr), 32'hF);
    rst_n = 1'b0;
    @(posedge clk); #1;
    refStore(3'd2, 32'h0000_4000, wd);
    checkOutput("mid_mem_wr_after", 32'(mem_wr), 32'd0);
    checkOutput("mid_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("mid_req_ready_after", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("mid_no_resp", 32'(resp_valid), 32'd0);
    checkOutput("mid_ready_idle", 32'(req_ready), 32'd1);

    $display("[TB] random requests");
    for (int t = 0; t < 200; t++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7)      addr = 32'($urandom_range(0, 63));
      else if (sel < 9) addr = 32'h0000_FFF8 + 32'($urandom_range(0, 7));
      else              addr = $urandom;
      applyStimulus(1'($urandom), 3'($urandom), addr, $urandom, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, failCnt);
    $finish;
  end

endmodule
